// File: rtl/error_combiner_pkg.sv
// Shared types and helpers for the weighted error combiner and related loop blocks.
package error_combiner_pkg;

  // Sequencer states: wait for a sample, accumulate one channel per cycle, publish result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Accumulator width that holds the sum of num_channels full signed products
  // without overflow: product width, plus growth for the channel count, plus one
  // guard bit for the asymmetric most-negative product.
  function automatic int acc_width(input int num_channels,
                                   input int error_width,
                                   input int weight_width);
    return error_width + weight_width + $clog2(num_channels) + 1;
  endfunction

  // Clamp a signed value to the range of an out_width-bit signed number.
  // Works on a 64-bit carrier so it can serve any input/output width up to 63 bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned      out_width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] result;
    max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      result = max_v;
    end else if (value < min_v) begin
      result = min_v;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/signed_saturator.sv
// Combinational signed saturator: narrows a signed value, clamping at the output range limits.
module signed_saturator
  import error_combiner_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  // Widen to the helper's 64-bit carrier, clamp, then keep the low OUT_WIDTH bits
  // (which carry the full clamped value by construction).
  assign dout = OUT_WIDTH'(saturate(64'(din), OUT_WIDTH));

endmodule

// File: rtl/weighted_error_combiner.sv
// Sequential weighted error combiner: snapshots NUM_CHANNELS signed errors and weights,
// accumulates en[k]*e[k]*w[k] with one shared multiplier, scales by an arithmetic right
// shift, saturates, and presents the result to the loop filter with a one-cycle strobe.
module weighted_error_combiner
  import error_combiner_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ERROR_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int OUT_WIDTH    = 8,
  parameter int FRAC_SHIFT   = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  sample_valid_i,
  input  logic [NUM_CHANNELS*ERROR_WIDTH-1:0]   errors_i,
  input  logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0]  weights_i,
  input  logic [NUM_CHANNELS-1:0]               channel_en_i,
  input  logic                                  clear_overrun_i,
  output logic [OUT_WIDTH-1:0]                  error_comb_o,
  output logic                                  error_valid_o,
  output logic                                  busy_o,
  output logic                                  overrun_o
);

  localparam int ACC_WIDTH  = acc_width(NUM_CHANNELS, ERROR_WIDTH, WEIGHT_WIDTH);
  localparam int PROD_WIDTH = ERROR_WIDTH + WEIGHT_WIDTH;
  localparam int IDX_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNELS - 1);

  state_t                                 state_reg;
  logic [NUM_CHANNELS*ERROR_WIDTH-1:0]    err_cap_reg;
  logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0]   wgt_cap_reg;
  logic [NUM_CHANNELS-1:0]                en_cap_reg;
  logic [IDX_WIDTH-1:0]                   idx_reg;
  logic signed [ACC_WIDTH-1:0]            acc_reg;
  logic signed [OUT_WIDTH-1:0]            error_comb_reg;
  logic                                   error_valid_reg;
  logic                                   busy_reg;
  logic                                   overrun_reg;

  logic signed [ERROR_WIDTH-1:0]          err_arr [NUM_CHANNELS];
  logic signed [WEIGHT_WIDTH-1:0]         wgt_arr [NUM_CHANNELS];
  logic signed [PROD_WIDTH-1:0]           product;
  logic signed [ACC_WIDTH-1:0]            product_ext;
  logic signed [ACC_WIDTH-1:0]            scaled;
  logic signed [OUT_WIDTH-1:0]            sat_value;

  // Split the captured packed vectors into per-channel signed lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
      assign err_arr[gi] = err_cap_reg[gi*ERROR_WIDTH +: ERROR_WIDTH];
      assign wgt_arr[gi] = wgt_cap_reg[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  endgenerate

  // The single shared multiplier works on the channel selected by idx_reg; a
  // disabled channel contributes zero. Operands are sign-extended to the full
  // product width first so the product is exact.
  assign product = en_cap_reg[idx_reg]
                 ? PROD_WIDTH'(err_arr[idx_reg]) * PROD_WIDTH'(wgt_arr[idx_reg])
                 : '0;
  assign product_ext = ACC_WIDTH'(product);

  // Arithmetic shift rounds toward minus infinity, which is the intended scaling.
  assign scaled = acc_reg >>> FRAC_SHIFT;

  signed_saturator #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_saturator (
    .din  (scaled),
    .dout (sat_value)
  );

  // Sequencer: capture on strobe, accumulate one channel per cycle, then register the result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      err_cap_reg     <= '0;
      wgt_cap_reg     <= '0;
      en_cap_reg      <= '0;
      idx_reg         <= '0;
      acc_reg         <= '0;
      error_comb_reg  <= '0;
      error_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      error_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sample_valid_i) begin
            err_cap_reg <= errors_i;
            wgt_cap_reg <= weights_i;
            en_cap_reg  <= channel_en_i;
            acc_reg     <= '0;
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ACCUM;
          end
        end
        ACCUM: begin
          acc_reg <= acc_reg + product_ext;
          if (idx_reg == LAST_IDX) begin
            state_reg <= OUTPUT;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        OUTPUT: begin
          error_comb_reg  <= sat_value;
          error_valid_reg <= 1'b1;
          busy_reg        <= 1'b0;
          state_reg       <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag: a strobe while busy sets it; a clear only wins when no new overrun.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overrun_reg <= 1'b0;
    end else if (sample_valid_i && busy_reg) begin
      overrun_reg <= 1'b1;
    end else if (clear_overrun_i) begin
      overrun_reg <= 1'b0;
    end
  end

  assign error_comb_o  = error_comb_reg;
  assign error_valid_o = error_valid_reg;
  assign busy_o        = busy_reg;
  assign overrun_o     = overrun_reg;

endmodule

// File: tb/tb_weighted_error_combiner.sv
// Self-checking bench for weighted_error_combiner: three instances cover the default
// configuration, FRAC_SHIFT=2 and an 8-channel / 12-bit-error configuration.
module tb_weighted_error_combiner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        sv_a = 0, clr_a = 0;
  logic [31:0] err_a = '0;
  logic [15:0] wgt_a = '0;
  logic [3:0]  en_a = '0;
  logic [7:0]  comb_a;
  logic        valid_a, busy_a, ovr_a;

  // Instance B: FRAC_SHIFT = 2
  logic        sv_b = 0, clr_b = 0;
  logic [31:0] err_b = '0;
  logic [15:0] wgt_b = '0;
  logic [3:0]  en_b = '0;
  logic [7:0]  comb_b;
  logic        valid_b, busy_b, ovr_b;

  // Instance C: 8 channels, 12-bit errors
  logic        sv_c = 0, clr_c = 0;
  logic [95:0] err_c = '0;
  logic [31:0] wgt_c = '0;
  logic [7:0]  en_c = '0;
  logic [7:0]  comb_c;
  logic        valid_c, busy_c, ovr_c;

  int checks = 0;
  int errors = 0;

  weighted_error_combiner dut_a (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sv_a), .errors_i(err_a),
    .weights_i(wgt_a), .channel_en_i(en_a), .clear_overrun_i(clr_a),
    .error_comb_o(comb_a), .error_valid_o(valid_a), .busy_o(busy_a), .overrun_o(ovr_a)
  );

  weighted_error_combiner #(.FRAC_SHIFT(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sv_b), .errors_i(err_b),
    .weights_i(wgt_b), .channel_en_i(en_b), .clear_overrun_i(clr_b),
    .error_comb_o(comb_b), .error_valid_o(valid_b), .busy_o(busy_b), .overrun_o(ovr_b)
  );

  weighted_error_combiner #(.NUM_CHANNELS(8), .ERROR_WIDTH(12)) dut_c (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sv_c), .errors_i(err_c),
    .weights_i(wgt_c), .channel_en_i(en_c), .clear_overrun_i(clr_c),
    .error_comb_o(comb_c), .error_valid_o(valid_c), .busy_o(busy_c), .overrun_o(ovr_c)
  );

  // Reference: plain integer weighted sum, floor division by 2^shift, clamp to out range.
  function automatic int ref_model(input int e[8], input int w[8], input int en,
                                   input int nch, input int shift, input int outw);
    longint sum, d, q, hi, lo;
    sum = 0;
    for (int k = 0; k < nch; k++)
      if (((en >> k) & 1) == 1) sum += longint'(e[k]) * longint'(w[k]);
    d = longint'(1) << shift;
    if (sum >= 0) q = sum / d;
    else          q = -((-sum + d - 1) / d);
    hi = (longint'(1) << (outw - 1)) - 1;
    lo = -hi - 1;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  function automatic int rand_s(input int bits);
    return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a sample to A for one cycle (cycle T); returns in cycle T+1.
  task automatic drive_a(input int e[8], input int w[8], input int en);
    for (int k = 0; k < 4; k++) begin
      err_a[k*8 +: 8] = 8'(e[k]);
      wgt_a[k*4 +: 4] = 4'(w[k]);
    end
    en_a = 4'(en);
    sv_a = 1'b1;
    tick;
    sv_a = 1'b0;
  endtask

  task automatic drive_b(input int e[8], input int w[8], input int en);
    for (int k = 0; k < 4; k++) begin
      err_b[k*8 +: 8] = 8'(e[k]);
      wgt_b[k*4 +: 4] = 4'(w[k]);
    end
    en_b = 4'(en);
    sv_b = 1'b1;
    tick;
    sv_b = 1'b0;
  endtask

  // Wait (bounded) for a valid strobe; lat is the cycle offset from the strobe cycle.
  task automatic wait_valid_a(input int start, output int res, output int lat);
    lat = start;
    while (valid_a !== 1'b1 && lat < start + 40) begin
      tick;
      lat++;
    end
    res = int'($signed(comb_a));
  endtask

  task automatic wait_valid_b(input int start, output int res, output int lat);
    lat = start;
    while (valid_b !== 1'b1 && lat < start + 40) begin
      tick;
      lat++;
    end
    res = int'($signed(comb_b));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (comb_a !== 8'd0)  begin errors++; $display("FAIL reset_comb: got %0h expected 0", comb_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (ovr_a !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_a); end
    checks++; if ({valid_b, busy_b, valid_c, busy_c} !== 4'b0) begin
      errors++; $display("FAIL reset_bc: got %b expected 0000", {valid_b, busy_b, valid_c, busy_c});
    end
    rst = 1'b0;
    tick;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic;
    int e[8] = '{10, -40, 10, 10, 0, 0, 0, 0};
    int w[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int exp_v;
    logic eb, ev;
    exp_v = ref_model(e, w, 15, 4, 0, 8);
    drive_a(e, w, 15);
    for (int c = 1; c <= 7; c++) begin
      // inputs wander after capture; the result must not follow them
      err_a = $urandom;
      wgt_a = 16'($urandom);
      en_a  = 4'($urandom);
      eb = (c <= 5);
      ev = (c == 6);
      checks++; if (busy_a !== eb)  begin errors++; $display("FAIL basic_busy T+%0d: got %b expected %b", c, busy_a, eb); end
      checks++; if (valid_a !== ev) begin errors++; $display("FAIL basic_valid T+%0d: got %b expected %b", c, valid_a, ev); end
      if (c >= 6) begin
        checks++;
        if (int'($signed(comb_a)) != exp_v) begin
          errors++; $display("FAIL basic_comb T+%0d: got %0d expected %0d", c, $signed(comb_a), exp_v);
        end
      end
      tick;
    end
    $display("basic: e={10,-40,10,10} w=1 expected %0d", exp_v);
  endtask

  task automatic test_saturation;
    int e[8], w[8];
    int res, lat, exp_v;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        e[k] = (s == 0) ? 127 : -128;
        w[k] = 7;
      end
      exp_v = ref_model(e, w, 15, 4, 0, 8);
      drive_a(e, w, 15);
      wait_valid_a(1, res, lat);
      checks++; if (lat != 6)     begin errors++; $display("FAIL sat_latency: got %0d expected 6", lat); end
      checks++; if (res != exp_v) begin errors++; $display("FAIL sat_value: got %0d expected %0d", res, exp_v); end
      $display("saturation: case %0d result %0d expected %0d", s, res, exp_v);
    end
  endtask

  task automatic test_random_a;
    int e[8], w[8];
    int en, res, lat, exp_v;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 8; k++) begin
        e[k] = rand_s(8);
        w[k] = rand_s(4);
      end
      en = int'($urandom_range(0, 15));
      exp_v = ref_model(e, w, en, 4, 0, 8);
      drive_a(e, w, en);
      wait_valid_a(1, res, lat);
      checks++; if (lat != 6)     begin errors++; $display("FAIL rand_a_latency: got %0d expected 6", lat); end
      checks++; if (res != exp_v) begin errors++; $display("FAIL rand_a_value: got %0d expected %0d", res, exp_v); end
      $display("random_a %0d: en=%b result %0d expected %0d", n, 4'(en), res, exp_v);
    end
  endtask

  task automatic test_overrun;
    int e[8], w[8];
    int res, lat, exp_v;
    for (int k = 0; k < 8; k++) begin e[k] = rand_s(8); w[k] = rand_s(4); end
    exp_v = ref_model(e, w, 15, 4, 0, 8);
    drive_a(e, w, 15);                       // now T+1
    tick;                                    // T+2
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", ovr_a); end
    err_a = $urandom; wgt_a = 16'($urandom); en_a = 4'hF;
    sv_a = 1'b1;
    tick;                                    // T+3
    sv_a = 1'b0;
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ovr_a); end
    wait_valid_a(3, res, lat);
    checks++; if (lat != 6)     begin errors++; $display("FAIL ovr_latency: got %0d expected 6", lat); end
    checks++; if (res != exp_v) begin errors++; $display("FAIL ovr_result: got %0d expected %0d", res, exp_v); end
    clr_a = 1'b1;
    tick;
    clr_a = 1'b0;
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear1: got %b expected 0", ovr_a); end
    $display("overrun: discarded strobe, result %0d expected %0d", res, exp_v);

    // set and clear in the same cycle: set wins
    for (int k = 0; k < 8; k++) begin e[k] = rand_s(8); w[k] = rand_s(4); end
    exp_v = ref_model(e, w, 15, 4, 0, 8);
    drive_a(e, w, 15);                       // T+1
    tick;                                    // T+2
    sv_a = 1'b1; clr_a = 1'b1;
    tick;                                    // T+3
    sv_a = 1'b0; clr_a = 1'b0;
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", ovr_a); end
    clr_a = 1'b1;
    tick;                                    // T+4
    clr_a = 1'b0;
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear2: got %b expected 0", ovr_a); end
    wait_valid_a(4, res, lat);
    checks++; if (lat != 6)     begin errors++; $display("FAIL ovr2_latency: got %0d expected 6", lat); end
    checks++; if (res != exp_v) begin errors++; $display("FAIL ovr2_result: got %0d expected %0d", res, exp_v); end
    $display("overrun: set-wins then clear, result %0d expected %0d", res, exp_v);
  endtask

  task automatic test_reset_mid;
    int e[8], w[8];
    int res, lat, exp_v;
    bit seen;
    for (int k = 0; k < 8; k++) begin e[k] = 50 + k; w[k] = 1; end
    drive_a(e, w, 15);                       // T+1
    tick;                                    // T+2
    sv_a = 1'b1;
    tick;                                    // T+3, mid-ACCUM
    sv_a = 1'b0;
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL mid_ovr_pre: got %b expected 1", ovr_a); end
    rst = 1'b1;
    #1;
    checks++; if (comb_a !== 8'd0)  begin errors++; $display("FAIL mid_comb: got %0h expected 0", comb_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", valid_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL mid_busy: got %b expected 0", busy_a); end
    checks++; if (ovr_a !== 1'b0)   begin errors++; $display("FAIL mid_ovr: got %b expected 0", ovr_a); end
    tick;
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (valid_a === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_valid: got %b expected 0", seen); end
    for (int k = 0; k < 8; k++) begin e[k] = rand_s(8); w[k] = rand_s(4); end
    exp_v = ref_model(e, w, 15, 4, 0, 8);
    drive_a(e, w, 15);
    wait_valid_a(1, res, lat);
    checks++; if (lat != 6)     begin errors++; $display("FAIL mid_latency: got %0d expected 6", lat); end
    checks++; if (res != exp_v) begin errors++; $display("FAIL mid_result: got %0d expected %0d", res, exp_v); end
    $display("reset_mid: aborted, restart result %0d expected %0d", res, exp_v);
  endtask

  task automatic test_shift;
    int e[8] = '{-5, 0, 0, 0, 0, 0, 0, 0};
    int w[8] = '{3, 0, 0, 0, 0, 0, 0, 0};
    int res, lat, exp_v, en;
    exp_v = ref_model(e, w, 15, 4, 2, 8);   // -15 >>> 2 = -4
    drive_b(e, w, 15);
    wait_valid_b(1, res, lat);
    checks++; if (lat != 6)     begin errors++; $display("FAIL shift_latency: got %0d expected 6", lat); end
    checks++; if (res != exp_v) begin errors++; $display("FAIL shift_floor: got %0d expected %0d", res, exp_v); end
    $display("shift: acc -15 result %0d expected %0d", res, exp_v);

    for (int k = 0; k < 4; k++) begin e[k] = 20 + k; w[k] = 3; end
    drive_b(e, w, 0);
    wait_valid_b(1, res, lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL dis_latency: got %0d expected 6", lat); end
    checks++; if (res != 0) begin errors++; $display("FAIL dis_value: got %0d expected 0", res); end
    $display("shift: all channels disabled result %0d", res);

    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 8; k++) begin e[k] = rand_s(8); w[k] = rand_s(4); end
      en = int'($urandom_range(0, 15));
      exp_v = ref_model(e, w, en, 4, 2, 8);
      drive_b(e, w, en);
      wait_valid_b(1, res, lat);
      checks++; if (res != exp_v) begin errors++; $display("FAIL shift_rand: got %0d expected %0d", res, exp_v); end
      $display("shift_rand %0d: result %0d expected %0d", n, res, exp_v);
    end
  endtask

  // Strobes at the tightest spacing the sequencer accepts: each new sample lands
  // in the same cycle as the previous result's valid strobe.
  task automatic test_back_to_back;
    int e[8], w[8];
    int exp_q[$];
    int due_q[$];
    int sent, got, en, ev, ed;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20 * 10 + 15; cyc++) begin
      if (cyc % 10 == 0 && sent < 20) begin
        for (int k = 0; k < 8; k++) begin
          e[k] = (sent % 2 == 1) ? rand_s(5) : rand_s(12);
          w[k] = rand_s(4);
          err_c[k*12 +: 12] = 12'(e[k]);
          wgt_c[k*4 +: 4]   = 4'(w[k]);
        end
        en = int'($urandom_range(0, 255));
        en_c = 8'(en);
        sv_c = 1'b1;
        exp_q.push_back(ref_model(e, w, en, 8, 0, 8));
        due_q.push_back(cyc + 10);
        sent++;
      end else begin
        sv_c = 1'b0;
      end
      if (valid_c === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got valid at cycle %0d expected none", cyc);
        end else begin
          ev = exp_q.pop_front();
          ed = due_q.pop_front();
          if (int'($signed(comb_c)) != ev) begin
            errors++; $display("FAIL b2b_value: got %0d expected %0d", $signed(comb_c), ev);
          end
          checks++;
          if (cyc != ed) begin errors++; $display("FAIL b2b_timing: got cycle %0d expected %0d", cyc, ed); end
          $display("b2b %0d: result %0d expected %0d", got, $signed(comb_c), ev);
          got++;
        end
      end
      tick;
    end
    sv_c = 1'b0;
    checks++; if (got != 20)      begin errors++; $display("FAIL b2b_count: got %0d expected 20", got); end
    checks++; if (ovr_c !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", ovr_c); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_random_a;
    test_overrun;
    test_reset_mid;
    test_shift;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
